// File: rtl/mem_responder.sv
// mem_responder: cpuv2 byte-bus responder with program/data RAM, UART TX/RX FIFOs
// and a cycle-counter snapshot in a 16-byte I/O window at the top of the address space.
module mem_responder #(
    parameter int ADDR_WIDTH     = 9,
    parameter int FIFO_DEPTH     = 16,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [7:0]            mem_data_in,
    input  logic                  mem_write,
    output logic [7:0]            mem_data_out,
    output logic                  mem_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);
    // state   | meaning
    // ST_INIT | after reset; zeroes RAM when CLEAR_ON_RESET, bus writes and FIFO traffic ignored
    // ST_RUN  | normal operation, mem_ready=1, cycle counter running

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW        = $clog2(FIFO_DEPTH);

    localparam logic [3:0] OFF_TX_DATA = 4'd0;
    localparam logic [3:0] OFF_STATUS  = 4'd1;
    localparam logic [3:0] OFF_RX_DATA = 4'd2;
    localparam logic [3:0] OFF_RX_POP  = 4'd3;
    localparam logic [3:0] OFF_SNAP0   = 4'd4;
    localparam logic [3:0] OFF_SNAP1   = 4'd5;
    localparam logic [3:0] OFF_SNAP2   = 4'd6;
    localparam logic [3:0] OFF_SNAP3   = 4'd7;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [7:0]            mem_data_out_q, mem_data_out_d;
    logic [PW:0]           tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PW:0]           tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PW:0]           rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PW:0]           rx_rd_ptr_q, rx_rd_ptr_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic [31:0]           counter_q, counter_d;
    logic [31:0]           snap_q, snap_d;

    logic [7:0] ram_q    [RAM_DEPTH];
    logic [7:0] tx_mem_q [FIFO_DEPTH];
    logic [7:0] rx_mem_q [FIFO_DEPTH];

    logic                  run;
    logic                  init_clear;
    logic                  raddr_io;
    logic                  waddr_io;
    logic                  io_wr;
    logic [3:0]            roff;
    logic [3:0]            woff;
    logic                  tx_empty, tx_full;
    logic                  rx_empty, rx_full;
    logic                  tx_pop, tx_push_req, tx_push;
    logic                  rx_pop, rx_push_req, rx_push;
    logic                  status_wr;
    logic                  snap_wr;
    logic [7:0]            status_byte;
    logic [7:0]            rx_head;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_wa;
    logic [7:0]            ram_wd;

    assign run        = (state_q == ST_RUN);
    assign init_clear = (state_q == ST_INIT) && CLEAR_ON_RESET;

    assign raddr_io = &mem_raddr[ADDR_WIDTH-1:4];
    assign waddr_io = &mem_waddr[ADDR_WIDTH-1:4];
    assign roff     = mem_raddr[3:0];
    assign woff     = mem_waddr[3:0];
    assign io_wr    = run && mem_write && waddr_io;

    // Full when the index bits match but the wrap bits differ.
    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full  = (tx_wr_ptr_q[PW] != tx_rd_ptr_q[PW]) &&
                      (tx_wr_ptr_q[PW-1:0] == tx_rd_ptr_q[PW-1:0]);
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full  = (rx_wr_ptr_q[PW] != rx_rd_ptr_q[PW]) &&
                      (rx_wr_ptr_q[PW-1:0] == rx_rd_ptr_q[PW-1:0]);

    assign tx_pop      = run && !tx_empty && tx_ready;
    assign tx_push_req = io_wr && (woff == OFF_TX_DATA);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    assign rx_pop      = io_wr && (woff == OFF_RX_POP) && !rx_empty;
    assign rx_push_req = run && rx_valid;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);

    assign status_wr = io_wr && (woff == OFF_STATUS);
    assign snap_wr   = io_wr && (woff == OFF_SNAP0);

    assign rx_head     = rx_mem_q[rx_rd_ptr_q[PW-1:0]];
    assign status_byte = {4'b0000, rx_ovf_q, tx_ovf_q, !rx_empty, tx_full};

    // Sequencing
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                    if (&clr_addr_q) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
        mem_ready_d = (state_d == ST_RUN);
    end

    // Read mux: all I/O reads are side-effect free and see pre-edge state.
    always_comb begin
        mem_data_out_d = ram_q[mem_raddr];
        if (raddr_io) begin
            case (roff)
                OFF_STATUS:  mem_data_out_d = status_byte;
                OFF_RX_DATA: mem_data_out_d = rx_empty ? 8'h00 : rx_head;
                OFF_SNAP0:   mem_data_out_d = snap_q[31:24];
                OFF_SNAP1:   mem_data_out_d = snap_q[23:16];
                OFF_SNAP2:   mem_data_out_d = snap_q[15:8];
                OFF_SNAP3:   mem_data_out_d = snap_q[7:0];
                default:     mem_data_out_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + (PW+1)'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + (PW+1)'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + (PW+1)'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + (PW+1)'(rx_pop);

        // Set beats write-1-to-clear on the same edge.
        tx_ovf_d = (tx_push_req && !tx_push) ||
                   (tx_ovf_q && !(status_wr && mem_data_in[2]));
        rx_ovf_d = (rx_push_req && !rx_push) ||
                   (rx_ovf_q && !(status_wr && mem_data_in[3]));

        counter_d = run ? counter_q + 32'd1 : counter_q;
        snap_d    = snap_wr ? counter_q : snap_q;
    end

    always_comb begin
        ram_we = 1'b0;
        ram_wa = mem_waddr;
        ram_wd = mem_data_in;
        if (!reset) begin
            if (init_clear) begin
                ram_we = 1'b1;
                ram_wa = clr_addr_q;
                ram_wd = 8'h00;
            end else if (run && mem_write && !waddr_io) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            clr_addr_q     <= '0;
            mem_ready_q    <= 1'b0;
            mem_data_out_q <= 8'h00;
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
            tx_ovf_q       <= 1'b0;
            rx_ovf_q       <= 1'b0;
            counter_q      <= 32'd0;
            snap_q         <= 32'd0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            mem_ready_q    <= mem_ready_d;
            mem_data_out_q <= mem_data_out_d;
            tx_wr_ptr_q    <= tx_wr_ptr_d;
            tx_rd_ptr_q    <= tx_rd_ptr_d;
            rx_wr_ptr_q    <= rx_wr_ptr_d;
            rx_rd_ptr_q    <= rx_rd_ptr_d;
            tx_ovf_q       <= tx_ovf_d;
            rx_ovf_q       <= rx_ovf_d;
            counter_q      <= counter_d;
            snap_q         <= snap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_wa] <= ram_wd;
        end
    end

    // Storage needs no reset; pointers alone define FIFO contents.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q[PW-1:0]] <= mem_data_in;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q[PW-1:0]] <= rx_data;
        end
    end

    assign mem_data_out = mem_data_out_q;
    assign mem_ready    = mem_ready_q;
    assign rx_ready     = mem_ready_q;
    assign tx_valid     = !tx_empty;
    assign tx_data      = tx_mem_q[tx_rd_ptr_q[PW-1:0]];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed steps plus random traffic checked every cycle
// against a queue/array reference model; a second instance exercises RAM clearing.
module tb_mem_responder;
    localparam int AW    = 9;
    localparam int DEPTH = 16;
    localparam int IO    = 2 ** AW - 16;

    logic          clk;
    logic          reset;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [7:0]    mem_data_in, mem_data_out;
    logic          mem_write, mem_ready;
    logic [7:0]    tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;

    logic          c_reset;
    logic [AW-1:0] c_raddr, c_waddr;
    logic [7:0]    c_data_in, c_data_out, c_tx_data, c_rx_data;
    logic          c_write, c_ready, c_tx_valid, c_tx_ready, c_rx_valid, c_rx_ready;

    mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) dut (
        .clk(clk), .reset(reset), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out),
        .mem_ready(mem_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready));

    mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut_clr (
        .clk(clk), .reset(c_reset), .mem_raddr(c_raddr), .mem_waddr(c_waddr),
        .mem_data_in(c_data_in), .mem_write(c_write), .mem_data_out(c_data_out),
        .mem_ready(c_ready), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
        .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0]  m_ram   [2**AW];
    bit          m_known [2**AW];
    logic [7:0]  m_txq [$];
    logic [7:0]  m_rxq [$];
    bit          m_run, m_tx_ovf, m_rx_ovf;
    logic [31:0] m_cnt, m_snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] io(input int k);
        return AW'(IO + k);
    endfunction

    function automatic logic [7:0] model_read(input logic [AW-1:0] a);
        logic [3:0] off;
        if (int'(a) < IO) return m_ram[a];
        off = 4'(int'(a) - IO);
        case (off)
            4'd1: return {4'b0000, m_rx_ovf, m_tx_ovf, m_rxq.size() != 0, m_txq.size() == DEPTH};
            4'd2: return (m_rxq.size() != 0) ? m_rxq[0] : 8'h00;
            4'd4: return m_snap[31:24];
            4'd5: return m_snap[23:16];
            4'd6: return m_snap[15:8];
            4'd7: return m_snap[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // One clock of the main instance: predict, advance the model, then compare.
    task automatic tick();
        logic [7:0] exp_rd;
        bit         rd_known;
        bit         wio, tx_set, rx_set;
        logic [3:0] wo;
        rd_known = 1'b1;
        exp_rd   = 8'h00;
        if (!reset) begin
            exp_rd   = model_read(mem_raddr);
            rd_known = (int'(mem_raddr) >= IO) || m_known[mem_raddr];
        end
        if (reset) begin
            m_txq.delete();
            m_rxq.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
            m_cnt    = 32'd0;
            m_snap   = 32'd0;
            m_run    = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else begin
            wio    = mem_write && (int'(mem_waddr) >= IO);
            wo     = 4'(int'(mem_waddr) - IO);
            tx_set = 1'b0;
            rx_set = 1'b0;
            if (m_txq.size() != 0 && tx_ready) void'(m_txq.pop_front());
            if (wio && wo == 4'd0) begin
                if (m_txq.size() < DEPTH) m_txq.push_back(mem_data_in);
                else tx_set = 1'b1;
            end
            if (wio && wo == 4'd3 && m_rxq.size() != 0) void'(m_rxq.pop_front());
            if (rx_valid) begin
                if (m_rxq.size() < DEPTH) m_rxq.push_back(rx_data);
                else rx_set = 1'b1;
            end
            if (wio && wo == 4'd1) begin
                if (mem_data_in[2]) m_tx_ovf = 1'b0;
                if (mem_data_in[3]) m_rx_ovf = 1'b0;
            end
            if (tx_set) m_tx_ovf = 1'b1;
            if (rx_set) m_rx_ovf = 1'b1;
            if (wio && wo == 4'd4) m_snap = m_cnt;
            if (mem_write && !wio) begin
                m_ram[mem_waddr]   = mem_data_in;
                m_known[mem_waddr] = 1'b1;
            end
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        if (rd_known) chk("rdata", mem_data_out, exp_rd);
        chk("mem_ready", mem_ready, m_run);
        chk("rx_ready", rx_ready, m_run);
        chk("tx_valid", tx_valid, m_txq.size() != 0);
        if (m_txq.size() != 0) chk("tx_data", tx_data, m_txq[0]);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        mem_write   = 1'b1;
        mem_waddr   = a;
        mem_data_in = d;
        tick();
        mem_write   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        mem_raddr = a;
        tick();
        chk(tag, mem_data_out, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (!c_ready && cnt < 2000) begin
            cyc();
            cnt++;
        end
        chk(tag, cnt, 512);
    endtask

    initial begin
        int nz;
        for (int i = 0; i < 2**AW; i++) begin
            m_known[i] = 1'b0;
            m_ram[i]   = 8'h00;
        end
        reset = 1'b1; mem_raddr = io(8); mem_waddr = '0; mem_data_in = 8'h00; mem_write = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        c_reset = 1'b1; c_raddr = '0; c_waddr = '0; c_data_in = 8'h00; c_write = 1'b0;
        c_tx_ready = 1'b0; c_rx_data = 8'h00; c_rx_valid = 1'b0;

        // Reset and first read/write
        tick(); tick();
        chk("rst_dout", mem_data_out, 8'h00);
        chk("rst_ready", mem_ready, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk("t1_ready_2nd_cycle", mem_ready, 1'b1);
        wr(9'h010, 8'hA5);
        rd_chk("t1_read_a5", 9'h010, 8'hA5);

        // Back-to-back reads and same-edge read/write
        wr(9'h020, 8'h5A);
        wr(9'h021, 8'hC3);
        rd_chk("t2_b2b_0", 9'h020, 8'h5A);
        rd_chk("t2_b2b_1", 9'h021, 8'hC3);
        wr(9'h030, 8'h11);
        mem_raddr = 9'h030;
        wr(9'h030, 8'h22);
        chk("t2_rw_old", mem_data_out, 8'h11);
        tick();
        chk("t2_rw_new", mem_data_out, 8'h22);

        for (int i = 0; i < 300; i++) begin
            mem_write   = 1'($urandom_range(0, 1));
            mem_waddr   = AW'($urandom_range(0, 63));
            mem_data_in = 8'($urandom);
            mem_raddr   = AW'($urandom_range(0, 63));
            tick();
        end
        mem_write = 1'b0;

        // TX overflow and drain
        tx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) wr(io(0), 8'(i));
        rd_chk("t3_status_full_ovf", io(1), 8'h05);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_tx_order", tx_data, 32'(i));
            tick();
        end
        chk("t3_tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;
        wr(io(1), 8'h04);
        rd_chk("t3_w1c_tx_ovf", io(1), 8'h00);

        // RX FIFO
        rx_valid = 1'b1; rx_data = 8'h41; tick();
        rx_data = 8'h42; tick();
        rx_valid = 1'b0;
        rd_chk("t4_status_nonempty", io(1), 8'h02);
        rd_chk("t4_head_41", io(2), 8'h41);
        wr(io(3), 8'h00);
        rd_chk("t4_head_42", io(2), 8'h42);
        wr(io(3), 8'h00);
        wr(io(3), 8'h00);
        rd_chk("t4_empty_reads_0", io(2), 8'h00);
        rd_chk("t4_status_empty", io(1), 8'h00);
        rx_valid = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            rx_data = 8'(8'h50 + i);
            tick();
        end
        rx_valid = 1'b0;
        rd_chk("t4_rx_ovf", io(1), 8'h0A);
        rd_chk("t4_head_50", io(2), 8'h50);
        rx_valid = 1'b1; rx_data = 8'h99;
        wr(io(1), 8'h08);
        rx_valid = 1'b0;
        rd_chk("t4_set_wins", io(1), 8'h0A);
        wr(io(1), 8'h08);
        rd_chk("t4_w1c_rx_ovf", io(1), 8'h02);
        rx_valid = 1'b1; rx_data = 8'h9A;
        wr(io(3), 8'h00);
        rx_valid = 1'b0;
        rd_chk("t4_push_pop_full", io(1), 8'h02);
        rd_chk("t4_head_51", io(2), 8'h51);

        // Reset flushes FIFOs; counter snapshot from a known start
        wr(io(0), 8'h77);
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        chk("rst_tx_flushed", tx_valid, 1'b0);
        repeat (10) tick();
        wr(io(4), 8'h00);
        rd_chk("snap_lsb_10", io(7), 8'h0A);
        rd_chk("snap_msb_0", io(4), 8'h00);
        rd_chk("rst_status_clear", io(1), 8'h00);

        for (int i = 0; i < 400; i++) begin
            tx_ready    = 1'($urandom_range(0, 1));
            rx_valid    = ($urandom_range(0, 2) == 0);
            rx_data     = 8'($urandom);
            mem_write   = 1'($urandom_range(0, 1));
            mem_waddr   = io($urandom_range(0, 4));
            mem_data_in = 8'($urandom);
            mem_raddr   = io($urandom_range(0, 8));
            tick();
        end
        mem_write = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;

        // Counter wrap
        force dut.counter_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        wr(io(4), 8'h00);
        release dut.counter_q;
        rd_chk("t5_snap4", io(4), 8'hFF);
        rd_chk("t5_snap5", io(5), 8'hFF);
        tick(); tick();
        rd_chk("t5_snap6", io(6), 8'hFF);
        rd_chk("t5_snap7", io(7), 8'hFE);

        // RAM clear on reset, restarted mid-clear
        c_reset = 1'b0;
        wait_clear("t6_first_clear_cycles");
        c_write = 1'b1; c_data_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            c_waddr = AW'(i * 123);
            cyc();
        end
        c_write = 1'b0;
        c_raddr = AW'(246);
        cyc();
        chk("t6_written", c_data_out, 8'hFF);
        c_reset = 1'b1; cyc();
        c_reset = 1'b0;
        repeat (100) cyc();
        chk("t6_mid_clear_not_ready", c_ready, 1'b0);
        c_reset = 1'b1; cyc();
        c_reset = 1'b0;
        wait_clear("t6_restart_clear_cycles");
        nz = 0;
        for (int a = 0; a < IO; a++) begin
            c_raddr = AW'(a);
            cyc();
            if (c_data_out !== 8'h00) nz++;
        end
        chk("t6_nonzero_bytes", nz, 0);
        c_raddr = io(1);
        cyc();
        chk("t6_status_empty", c_data_out, 8'h00);
        chk("t6_tx_valid", c_tx_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
